ddr_mrs_sequencer: RTL

//  Sequences a DDR4 mode-register update whenever the host config changes (CL/BL/AL/CWL/RD_PRE/WR_PRE).

---
 rtl/ddr_mrs_sequencer_pkg.sv | 89 ++++++++
 rtl/ddr_mrs_sequencer_if.sv | 21 ++
 rtl/ddr_mrs_sequencer_timer.sv | 26 ++
 rtl/ddr_mrs_sequencer.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/ddr_mrs_sequencer_pkg.sv
// Shared types, defaults and mode-register encoders for the DDR4 MRS update sequencer.
package ddr_mrs_sequencer_pkg;

  localparam int DEF_T_RP  = 12;
  localparam int DEF_T_MRD = 8;
  localparam int DEF_T_MOD = 24;
  localparam int DEF_CNT_W = 6;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_PREA = 2'b01,
    CMD_MRS  = 2'b10
  } cmd_type_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_PREA,
    ST_WAIT_RP,
    ST_MRS,
    ST_WAIT_MRD,
    ST_WAIT_MOD
  } mrs_state_t;

  typedef struct packed {
    logic [2:0] cl;
    logic [2:0] bl;
    logic [2:0] al;
    logic [2:0] cwl;
    logic       rd_pre;
    logic       wr_pre;
  } mrs_cfg_t;

  // Issue order is MR4, MR2, MR1, MR0; two bits per slot, slot 0 in the LSBs.
  localparam logic [7:0] MR_BG = 8'b00_00_00_01;
  localparam logic [7:0] MR_BA = 8'b00_01_10_00;

  // PREA drives A10 high so every bank is closed.
  localparam logic [17:0] PREA_ADDR = 18'h00400;

  function automatic logic [17:0] enc_mr0(mrs_cfg_t c);
    logic [17:0] w;
    w      = '0;
    w[6:4] = c.cl;
    w[1:0] = (c.bl < 3'd3) ? c.bl[1:0] : 2'b00;
    return w;
  endfunction

  function automatic logic [17:0] enc_mr1(mrs_cfg_t c);
    logic [17:0] w;
    w      = '0;
    w[0]   = 1'b1;
    w[4:3] = (c.al < 3'd3) ? c.al[1:0] : 2'b00;
    return w;
  endfunction

  function automatic logic [17:0] enc_mr2(mrs_cfg_t c);
    logic [17:0] w;
    w      = '0;
    w[5:3] = c.cwl;
    return w;
  endfunction

  function automatic logic [17:0] enc_mr4(mrs_cfg_t c);
    logic [17:0] w;
    w     = '0;
    w[11] = c.rd_pre;
    w[12] = c.wr_pre;
    return w;
  endfunction

  function automatic logic [17:0] mr_word(logic [1:0] idx, mrs_cfg_t c);
    case (idx)
      2'd0:    return enc_mr4(c);
      2'd1:    return enc_mr2(c);
      2'd2:    return enc_mr1(c);
      default: return enc_mr0(c);
    endcase
  endfunction

  function automatic logic [1:0] mr_bg(logic [1:0] idx);
    return MR_BG[int'(idx)*2 +: 2];
  endfunction

  function automatic logic [1:0] mr_ba(logic [1:0] idx);
    return MR_BA[int'(idx)*2 +: 2];
  endfunction

endpackage

// File: rtl/ddr_mrs_sequencer_if.sv
// Command-bus request/grant link between the MRS sequencer and the command arbiter.
interface ddr_mrs_sequencer_if;
  import ddr_mrs_sequencer_pkg::*;

  logic        cmd_valid;
  logic        cmd_gnt;
  cmd_type_t   cmd_type;
  logic [1:0]  cmd_bg;
  logic [1:0]  cmd_ba;
  logic [17:0] cmd_addr;

  modport master (
    output cmd_valid, cmd_type, cmd_bg, cmd_ba, cmd_addr,
    input  cmd_gnt
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_bg, cmd_ba, cmd_addr,
    output cmd_gnt
  );
endinterface

// File: rtl/ddr_mrs_sequencer_timer.sv
// Loadable down-counter that saturates at zero; used for tRP/tMRD/tMOD spacing.
module ddr_cmd_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk_sys,
  input  logic             rst_b,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ddr_mrs_sequencer.sv
// Gates host traffic, drains the controller, then issues PREA and MRS to MR4/MR2/MR1/MR0.
//   state       | meaning
//   ST_IDLE     | traffic open unless an update is pending
//   ST_DRAIN    | traffic closed, waiting for ctrl_busy to fall
//   ST_PREA     | requesting precharge-all
//   ST_WAIT_RP  | tRP spacing before the first MRS
//   ST_MRS      | requesting MRS to the register selected by mr_idx
//   ST_WAIT_MRD | tMRD spacing between MRS commands
//   ST_WAIT_MOD | tMOD spacing before traffic reopens
module ddr_mrs_sequencer
  import ddr_mrs_sequencer_pkg::*;
#(
  parameter int T_RP  = DEF_T_RP,
  parameter int T_MRD = DEF_T_MRD,
  parameter int T_MOD = DEF_T_MOD,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic       CK_t,
  input  logic       RESET_n,
  input  logic       mrs_update,
  input  logic [2:0] CL,
  input  logic [2:0] BL,
  input  logic [2:0] AL,
  input  logic [2:0] CWL,
  input  logic       RD_PRE,
  input  logic       WR_PRE,
  input  logic       ctrl_busy,
  output logic       cmd_rdy,
  output logic       mrs_done,
  output logic       cfg_err,
  ddr_mrs_sequencer_if.master cmd
);

  mrs_state_t       state, state_nxt;
  mrs_cfg_t         shadow, run_cfg;
  logic             pending;
  logic [1:0]       mr_idx;
  logic             leave_idle;
  logic             tmr_load, tmr_dec, tmr_zero, tmr_tc;
  logic [CNT_W-1:0] tmr_val, tmr_cnt;
  logic             idx_inc, done_set;

  assign leave_idle = (state == ST_IDLE) && pending;
  assign cmd_rdy    = (state == ST_IDLE) && !pending;
  // Leaving a WAIT one count early makes the handshake-to-handshake gap exactly T.
  assign tmr_tc     = (tmr_cnt <= CNT_W'(1));

  ddr_cmd_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_sys  (CK_t),
    .rst_b    (RESET_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .cnt      (tmr_cnt),
    .zero     (tmr_zero)
  );

  // A capture always re-arms pending, even when it lands on the cycle IDLE is left.
  always_ff @(posedge CK_t or negedge RESET_n) begin
    if (!RESET_n) begin
      shadow  <= '0;
      run_cfg <= '0;
      pending <= 1'b1;
      cfg_err <= 1'b0;
    end else begin
      if (mrs_update) begin
        shadow  <= {CL, BL, AL, CWL, RD_PRE, WR_PRE};
        cfg_err <= (BL >= 3'd3) || (AL >= 3'd3);
      end
      if (mrs_update) begin
        pending <= 1'b1;
      end else if (leave_idle) begin
        pending <= 1'b0;
      end
      if (leave_idle) begin
        run_cfg <= shadow;
      end
    end
  end

  always_ff @(posedge CK_t or negedge RESET_n) begin
    if (!RESET_n) begin
      state    <= ST_IDLE;
      mr_idx   <= 2'd0;
      mrs_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      mrs_done <= done_set;
      if (leave_idle) begin
        mr_idx <= 2'd0;
      end else if (idx_inc) begin
        mr_idx <= mr_idx + 2'd1;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    tmr_load      = 1'b0;
    tmr_val       = '0;
    tmr_dec       = 1'b0;
    idx_inc       = 1'b0;
    done_set      = 1'b0;
    cmd.cmd_valid = 1'b0;
    cmd.cmd_type  = CMD_NOP;
    cmd.cmd_bg    = 2'b00;
    cmd.cmd_ba    = 2'b00;
    cmd.cmd_addr  = '0;
    unique case (state)
      ST_IDLE: begin
        if (pending) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!ctrl_busy) state_nxt = ST_PREA;
      end
      ST_PREA: begin
        cmd.cmd_valid = 1'b1;
        cmd.cmd_type  = CMD_PREA;
        cmd.cmd_addr  = PREA_ADDR;
        if (cmd.cmd_gnt) begin
          tmr_load  = 1'b1;
          tmr_val   = CNT_W'(T_RP - 1);
          state_nxt = ST_WAIT_RP;
        end
      end
      ST_WAIT_RP: begin
        tmr_dec = 1'b1;
        if (tmr_tc) state_nxt = ST_MRS;
      end
      ST_MRS: begin
        cmd.cmd_valid = 1'b1;
        cmd.cmd_type  = CMD_MRS;
        cmd.cmd_bg    = mr_bg(mr_idx);
        cmd.cmd_ba    = mr_ba(mr_idx);
        cmd.cmd_addr  = mr_word(mr_idx, run_cfg);
        if (cmd.cmd_gnt) begin
          idx_inc  = 1'b1;
          tmr_load = 1'b1;
          if (mr_idx == 2'd3) begin
            tmr_val   = CNT_W'(T_MOD - 1);
            state_nxt = ST_WAIT_MOD;
          end else begin
            tmr_val   = CNT_W'(T_MRD - 1);
            state_nxt = ST_WAIT_MRD;
          end
        end
      end
      ST_WAIT_MRD: begin
        tmr_dec = 1'b1;
        if (tmr_tc) state_nxt = ST_MRS;
      end
      ST_WAIT_MOD: begin
        tmr_dec = 1'b1;
        // Running down to zero here adds the IDLE-entry cycle to tMOD.
        if (tmr_zero) begin
          state_nxt = ST_IDLE;
          done_set  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
